// File: rtl/id_stage_pipelined.sv
// Instruction-decode stage with an owned register file, RAW hazard detection
// and the ID/EXE pipeline register (freeze, flush, conditional retire).
module id_stage_pipelined #(
    parameter int DATA_W     = 32,
    parameter int NUM_REGS   = 16,
    parameter bit FORWARD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [31:0]       instruction,
    input  logic [DATA_W-1:0] pc_in,
    input  logic              freeze,
    input  logic              flush,
    input  logic [3:0]        sr,
    input  logic              wb_en_in,
    input  logic [3:0]        dest_wb,
    input  logic [DATA_W-1:0] result_wb,
    input  logic              exe_wb_en,
    input  logic              exe_mem_r_en,
    input  logic [3:0]        exe_dest,
    input  logic              mem_wb_en,
    input  logic [3:0]        mem_dest,
    output logic              hazard,
    output logic              out_valid,
    output logic              wb_en,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic              b,
    output logic              s,
    output logic [3:0]        exe_cmd,
    output logic [DATA_W-1:0] val_rn,
    output logic [DATA_W-1:0] val_rm,
    output logic [DATA_W-1:0] pc_out,
    output logic              imm,
    output logic [11:0]       shift_operand,
    output logic [23:0]       signed_imm_24,
    output logic [3:0]        dest,
    output logic [3:0]        src1,
    output logic [3:0]        src2
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [3:0] {
        CMD_NOP = 4'd0,
        CMD_MOV = 4'd1,
        CMD_ADD = 4'd2,
        CMD_ADC = 4'd3,
        CMD_SUB = 4'd4,
        CMD_SBC = 4'd5,
        CMD_AND = 4'd6,
        CMD_ORR = 4'd7,
        CMD_EOR = 4'd8,
        CMD_MVN = 4'd9
    } exe_cmd_e;

    logic [3:0] cond;
    logic [1:0] mode;
    logic       i_bit;
    logic [3:0] opcode;
    logic       s_bit;
    logic [3:0] rn_idx;
    logic [3:0] rd_idx;
    logic [3:0] rm_idx;

    assign cond   = instruction[31:28];
    assign mode   = instruction[27:26];
    assign i_bit  = instruction[25];
    assign opcode = instruction[24:21];
    assign s_bit  = instruction[20];
    assign rn_idx = instruction[19:16];
    assign rd_idx = instruction[15:12];
    assign rm_idx = instruction[3:0];

    exe_cmd_e dec_cmd;
    logic     dec_wb, dec_mr, dec_mw, dec_b, dec_s;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        dec_cmd = CMD_NOP;
        dec_wb  = 1'b0;
        dec_mr  = 1'b0;
        dec_mw  = 1'b0;
        dec_b   = 1'b0;
        dec_s   = 1'b0;
        case (mode)
            2'b00: begin
                dec_s = s_bit;
                case (opcode)
                    4'b1101: begin dec_cmd = CMD_MOV; dec_wb = 1'b1; end
                    4'b1111: begin dec_cmd = CMD_MVN; dec_wb = 1'b1; end
                    4'b0100: begin dec_cmd = CMD_ADD; dec_wb = 1'b1; end
                    4'b0101: begin dec_cmd = CMD_ADC; dec_wb = 1'b1; end
                    4'b0010: begin dec_cmd = CMD_SUB; dec_wb = 1'b1; end
                    4'b0110: begin dec_cmd = CMD_SBC; dec_wb = 1'b1; end
                    4'b0000: begin dec_cmd = CMD_AND; dec_wb = 1'b1; end
                    4'b1100: begin dec_cmd = CMD_ORR; dec_wb = 1'b1; end
                    4'b0001: begin dec_cmd = CMD_EOR; dec_wb = 1'b1; end
                    4'b1010: dec_cmd = CMD_SUB;  // CMP: flags only
                    4'b1000: dec_cmd = CMD_AND;  // TST: flags only
                    default: dec_cmd = CMD_NOP;
                endcase
            end
            2'b01: begin
                dec_cmd = CMD_ADD;
                if (s_bit) begin
                    dec_mr = 1'b1;
                    dec_wb = 1'b1;
                end else begin
                    dec_mw = 1'b1;
                end
            end
            2'b10:   dec_b = 1'b1;
            default: dec_b = 1'b0;
        endcase
    end

    logic flag_n, flag_z, flag_c, flag_v;
    logic cond_pass;

    assign {flag_n, flag_z, flag_c, flag_v} = sr;

    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = ~flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = ~flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = ~flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = ~flag_v;
            4'b1000: cond_pass = flag_c & ~flag_z;
            4'b1001: cond_pass = ~flag_c | flag_z;
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_pass = flag_z | (flag_n != flag_v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Stores read their data register through the second port.
    logic [3:0] src1_idx, src2_idx;
    logic       two_src;

    assign src1_idx = rn_idx;
    assign src2_idx = dec_mw ? rd_idx : rm_idx;
    assign two_src  = ~i_bit | dec_mw;

    logic hit1, hit2;

    always_comb begin
        if (FORWARD_EN) begin
            hit1 = exe_wb_en && exe_mem_r_en && (src1_idx == exe_dest);
            hit2 = exe_wb_en && exe_mem_r_en && (src2_idx == exe_dest);
        end else begin
            hit1 = (exe_wb_en && (src1_idx == exe_dest)) || (mem_wb_en && (src1_idx == mem_dest));
            hit2 = (exe_wb_en && (src2_idx == exe_dest)) || (mem_wb_en && (src2_idx == mem_dest));
        end
    end

    assign hazard = in_valid & ((~dec_b & hit1) | (two_src & hit2));

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] rd_rn, rd_rm;

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the register file is reset entry by entry because the architecture
        // guarantees all-zero registers after reset; this rules out a RAM macro.
        if (!rst) begin
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
        end else if (wb_en_in && (int'(dest_wb) < NUM_REGS)) begin
            regs[dest_wb[IDX_W-1:0]] <= result_wb;
        end
    end

    always_comb begin
        rd_rn = '0;
        if (int'(src1_idx) < NUM_REGS) begin
            if (wb_en_in && (dest_wb == src1_idx)) rd_rn = result_wb;
            else                                   rd_rn = regs[src1_idx[IDX_W-1:0]];
        end
    end

    always_comb begin
        rd_rm = '0;
        if (int'(src2_idx) < NUM_REGS) begin
            if (wb_en_in && (dest_wb == src2_idx)) rd_rm = result_wb;
            else                                   rd_rm = regs[src2_idx[IDX_W-1:0]];
        end
    end

    logic ctrl_ok;

    assign ctrl_ok = in_valid & ~hazard & cond_pass;

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (!rst) begin
            out_valid     <= 1'b0;
            wb_en         <= 1'b0;
            mem_r_en      <= 1'b0;
            mem_w_en      <= 1'b0;
            b             <= 1'b0;
            s             <= 1'b0;
            exe_cmd       <= '0;
            val_rn        <= '0;
            val_rm        <= '0;
            pc_out        <= '0;
            imm           <= 1'b0;
            shift_operand <= '0;
            signed_imm_24 <= '0;
            dest          <= '0;
            src1          <= '0;
            src2          <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            wb_en     <= 1'b0;
            mem_r_en  <= 1'b0;
            mem_w_en  <= 1'b0;
            b         <= 1'b0;
            s         <= 1'b0;
            exe_cmd   <= '0;
        end else if (!freeze) begin
            // A condition-failed instruction still retires as a valid no-op.
            out_valid     <= in_valid & ~hazard;
            wb_en         <= ctrl_ok & dec_wb;
            mem_r_en      <= ctrl_ok & dec_mr;
            mem_w_en      <= ctrl_ok & dec_mw;
            b             <= ctrl_ok & dec_b;
            s             <= ctrl_ok & dec_s;
            exe_cmd       <= ctrl_ok ? dec_cmd : CMD_NOP;
            val_rn        <= rd_rn;
            val_rm        <= rd_rm;
            pc_out        <= pc_in;
            imm           <= i_bit;
            shift_operand <= instruction[11:0];
            signed_imm_24 <= instruction[23:0];
            dest          <= rd_idx;
            src1          <= src1_idx;
            src2          <= src2_idx;
        end
    end

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Scoreboard bench for id_stage_pipelined: directed vectors push expectations,
// a monitor pops and compares after every clock edge or reset assertion.
module tb_id_stage_pipelined;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] instruction;
    logic [31:0] pc_in;
    logic        freeze, flush;
    logic [3:0]  sr;
    logic        wb_en_in;
    logic [3:0]  dest_wb;
    logic [31:0] result_wb;
    logic        exe_wb_en, exe_mem_r_en;
    logic [3:0]  exe_dest;
    logic        mem_wb_en;
    logic [3:0]  mem_dest;

    logic        hazard, out_valid, wb_en, mem_r_en, mem_w_en, b, s, imm;
    logic [3:0]  exe_cmd, dest, src1, src2;
    logic [31:0] val_rn, val_rm, pc_out;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;

    logic        nf_hazard, nf_out_valid, nf_wb_en, nf_mem_r_en, nf_mem_w_en, nf_b, nf_s, nf_imm;
    logic [3:0]  nf_exe_cmd, nf_dest, nf_src1, nf_src2;
    logic [31:0] nf_val_rn, nf_val_rm, nf_pc_out;
    logic [11:0] nf_shift_operand;
    logic [23:0] nf_signed_imm_24;

    id_stage_pipelined #(.DATA_W(32), .NUM_REGS(16), .FORWARD_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instruction(instruction), .pc_in(pc_in),
        .freeze(freeze), .flush(flush), .sr(sr), .wb_en_in(wb_en_in), .dest_wb(dest_wb),
        .result_wb(result_wb), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .exe_dest(exe_dest), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
        .hazard(hazard), .out_valid(out_valid), .wb_en(wb_en), .mem_r_en(mem_r_en),
        .mem_w_en(mem_w_en), .b(b), .s(s), .exe_cmd(exe_cmd), .val_rn(val_rn), .val_rm(val_rm),
        .pc_out(pc_out), .imm(imm), .shift_operand(shift_operand), .signed_imm_24(signed_imm_24),
        .dest(dest), .src1(src1), .src2(src2)
    );

    // Second instance: no forwarding and only 8 implemented registers.
    id_stage_pipelined #(.DATA_W(32), .NUM_REGS(8), .FORWARD_EN(1'b0)) u_dut_nf (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instruction(instruction), .pc_in(pc_in),
        .freeze(freeze), .flush(flush), .sr(sr), .wb_en_in(wb_en_in), .dest_wb(dest_wb),
        .result_wb(result_wb), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .exe_dest(exe_dest), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
        .hazard(nf_hazard), .out_valid(nf_out_valid), .wb_en(nf_wb_en), .mem_r_en(nf_mem_r_en),
        .mem_w_en(nf_mem_w_en), .b(nf_b), .s(nf_s), .exe_cmd(nf_exe_cmd), .val_rn(nf_val_rn),
        .val_rm(nf_val_rm), .pc_out(nf_pc_out), .imm(nf_imm), .shift_operand(nf_shift_operand),
        .signed_imm_24(nf_signed_imm_24), .dest(nf_dest), .src1(nf_src1), .src2(nf_src2)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          m_hz;
        logic        hz, hz_nf;
        bit          m_ctl;
        logic        ov, wb, mr, mw, br, sf;
        logic [3:0]  cmd;
        bit          m_dat;
        logic [31:0] rn, rm, rm_nf, pc;
        logic [3:0]  dst;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    localparam logic [31:0] ADD_R2_R0_R1  = 32'hE0802001;
    localparam logic [31:0] ADD_R2_R0_R9  = 32'hE0802009;
    localparam logic [31:0] ADDI_R2_R0_1  = 32'hE2802001;
    localparam logic [31:0] MOVEQ_R1_5    = 32'h03A01005;
    localparam logic [31:0] STR_R1_R0     = 32'hE5801000;
    localparam logic [31:0] B_FWD         = 32'hEA000010;
    localparam logic [31:0] SUBS_R3_R1_R1 = 32'hE0513001;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic exp_t blank(input string n);
        exp_t e;
        e.name = n;
        e.m_hz = 1'b0; e.hz = 1'b0; e.hz_nf = 1'b0;
        e.m_ctl = 1'b0; e.ov = 1'b0; e.wb = 1'b0; e.mr = 1'b0; e.mw = 1'b0;
        e.br = 1'b0; e.sf = 1'b0; e.cmd = 4'd0;
        e.m_dat = 1'b0; e.rn = '0; e.rm = '0; e.rm_nf = '0; e.pc = '0; e.dst = 4'd0;
        return e;
    endfunction

    function automatic exp_t with_hz(input exp_t e, input logic h, input logic hnf);
        e.m_hz = 1'b1; e.hz = h; e.hz_nf = hnf;
        return e;
    endfunction

    function automatic exp_t with_ctl(input exp_t e, input logic ov, input logic wb, input logic mr,
                                      input logic mw, input logic br, input logic sf, input logic [3:0] cmd);
        e.m_ctl = 1'b1; e.ov = ov; e.wb = wb; e.mr = mr; e.mw = mw; e.br = br; e.sf = sf; e.cmd = cmd;
        return e;
    endfunction

    function automatic exp_t with_dat(input exp_t e, input logic [31:0] rn, input logic [31:0] rm,
                                      input logic [31:0] rm_nf, input logic [3:0] dst, input logic [31:0] pc);
        e.m_dat = 1'b1; e.rn = rn; e.rm = rm; e.rm_nf = rm_nf; e.dst = dst; e.pc = pc;
        return e;
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        in_valid = v; instruction = ins; pc_in = pc;
    endtask

    task automatic set_wb(input logic en, input logic [3:0] d, input logic [31:0] r);
        wb_en_in = en; dest_wb = d; result_wb = r;
    endtask

    task automatic set_fw(input logic ewb, input logic emr, input logic [3:0] ed,
                          input logic mwb, input logic [3:0] md);
        exe_wb_en = ewb; exe_mem_r_en = emr; exe_dest = ed; mem_wb_en = mwb; mem_dest = md;
    endtask

    task automatic cycle(input exp_t e);
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: outputs settle just after each clock edge or reset assertion.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge rst);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.m_hz) begin
                    check({e.name, ".hazard"}, 32'(hazard), 32'(e.hz));
                    check({e.name, ".hazard_nofwd"}, 32'(nf_hazard), 32'(e.hz_nf));
                end
                if (e.m_ctl) begin
                    check({e.name, ".out_valid"}, 32'(out_valid), 32'(e.ov));
                    check({e.name, ".wb_en"}, 32'(wb_en), 32'(e.wb));
                    check({e.name, ".mem_r_en"}, 32'(mem_r_en), 32'(e.mr));
                    check({e.name, ".mem_w_en"}, 32'(mem_w_en), 32'(e.mw));
                    check({e.name, ".b"}, 32'(b), 32'(e.br));
                    check({e.name, ".s"}, 32'(s), 32'(e.sf));
                    check({e.name, ".exe_cmd"}, 32'(exe_cmd), 32'(e.cmd));
                end
                if (e.m_dat) begin
                    check({e.name, ".val_rn"}, val_rn, e.rn);
                    check({e.name, ".val_rm"}, val_rm, e.rm);
                    check({e.name, ".val_rm_nofwd"}, nf_val_rm, e.rm_nf);
                    check({e.name, ".dest"}, 32'(dest), 32'(e.dst));
                    check({e.name, ".pc_out"}, pc_out, e.pc);
                end
            end
        end
    end

    initial begin
        exp_t fz;
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        freeze = 1'b0; flush = 1'b0; sr = 4'b0000;
        set_wb(1'b0, 4'd0, 32'h0);
        set_fw(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
        #2;
        q.push_back(with_dat(with_ctl(with_hz(blank("reset"), 1'b0, 1'b0),
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0), 32'h0, 32'h0, 32'h0, 4'd0, 32'h0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        set_wb(1'b1, 4'd1, 32'h5);
        cycle(with_ctl(blank("wr_r1"), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
        set_wb(1'b1, 4'd9, 32'h99);
        cycle(with_hz(blank("wr_r9"), 1'b0, 1'b0));
        set_wb(1'b0, 4'd0, 32'h0);

        drive(1'b1, ADD_R2_R0_R1, 32'h100);
        cycle(with_dat(with_ctl(with_hz(blank("add"), 1'b0, 1'b0),
              1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2), 32'h0, 32'h5, 32'h5, 4'd2, 32'h100));

        set_wb(1'b1, 4'd1, 32'h77);
        drive(1'b1, ADD_R2_R0_R1, 32'h104);
        cycle(with_dat(with_ctl(blank("bypass"), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2),
              32'h0, 32'h77, 32'h77, 4'd2, 32'h104));
        set_wb(1'b0, 4'd0, 32'h0);

        drive(1'b1, ADD_R2_R0_R9, 32'h108);
        cycle(with_dat(with_ctl(blank("r9_range"), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2),
              32'h0, 32'h99, 32'h0, 4'd2, 32'h108));

        drive(1'b1, ADD_R2_R0_R1, 32'h10C);
        set_fw(1'b1, 1'b1, 4'd0, 1'b0, 4'd0);
        cycle(with_ctl(with_hz(blank("load_use"), 1'b1, 1'b1),
              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));

        set_fw(1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
        cycle(with_ctl(with_hz(blank("exe_alu"), 1'b0, 1'b1),
              1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2));

        set_fw(1'b0, 1'b0, 4'd0, 1'b1, 4'd1);
        cycle(with_ctl(with_hz(blank("mem_raw"), 1'b0, 1'b1),
              1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2));

        drive(1'b1, ADDI_R2_R0_1, 32'h110);
        cycle(with_dat(with_ctl(with_hz(blank("imm_nosrc2"), 1'b0, 1'b0),
              1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2), 32'h0, 32'h77, 32'h77, 4'd2, 32'h110));
        set_fw(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);

        drive(1'b1, MOVEQ_R1_5, 32'h114);
        sr = 4'b0000;
        cycle(with_ctl(blank("moveq_fail"), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
        sr = 4'b0100;
        cycle(with_ctl(blank("moveq_pass"), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1));
        sr = 4'b0000;

        drive(1'b1, STR_R1_R0, 32'h118);
        cycle(with_dat(with_ctl(blank("str"), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2),
              32'h0, 32'h77, 32'h77, 4'd1, 32'h118));

        drive(1'b1, B_FWD, 32'h11C);
        cycle(with_ctl(blank("branch"), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0));

        drive(1'b1, SUBS_R3_R1_R1, 32'h120);
        cycle(with_dat(with_ctl(blank("subs"), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4),
              32'h77, 32'h77, 32'h77, 4'd3, 32'h120));

        drive(1'b1, ADD_R2_R0_R1, 32'h200);
        fz = with_dat(with_ctl(blank("freeze"), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2),
                      32'h0, 32'h77, 32'h77, 4'd2, 32'h200);
        cycle(fz);

        // Writeback continues while the pipeline register is frozen.
        freeze = 1'b1;
        drive(1'b1, SUBS_R3_R1_R1, 32'h300);
        set_wb(1'b1, 4'd0, 32'h11);
        cycle(fz);
        set_wb(1'b0, 4'd0, 32'h0);
        cycle(fz);
        cycle(fz);

        flush = 1'b1;
        cycle(with_ctl(blank("flush_freeze"), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
        flush = 1'b0;
        freeze = 1'b0;

        drive(1'b1, ADD_R2_R0_R1, 32'h400);
        cycle(with_dat(with_ctl(blank("after_freeze"), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2),
              32'h11, 32'h77, 32'h77, 4'd2, 32'h400));

        drive(1'b0, ADD_R2_R0_R1, 32'h500);
        #2;
        q.push_back(with_dat(with_ctl(with_hz(blank("async_rst"), 1'b0, 1'b0),
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0), 32'h0, 32'h0, 32'h0, 4'd0, 32'h0));
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        drive(1'b1, ADD_R2_R0_R1, 32'h600);
        cycle(with_dat(with_ctl(blank("post_rst"), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2),
              32'h0, 32'h0, 32'h0, 4'd2, 32'h600));
        drive(1'b0, 32'h0, 32'h0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        check("scoreboard_drain", 32'(q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
